// File: rtl/regfile_wb_arbiter_pkg.sv
// regctrl_pkg: types and default sizes shared by the register-file
// writeback arbiter and its round-robin sub-block.
//   wb_src_e  : identifies which writeback requester owns a grant
//   RF_WIDTH  : default register data width (matches reg2r1w)
//   RF_DEPTH  : default register count (matches reg2r1w)
package regctrl_pkg;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    localparam int RF_WIDTH = 8;
    localparam int RF_DEPTH = 16;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
//   req  [1:0] in  : request vector (bit 0 = ALU, bit 1 = LSU)
//   last       in  : id of the most recent grant
//   gnt  [1:0] out : one-hot grant, zero when no request
// A lone requester is always granted; under contention the requester
// that did not win last time is granted. The pointer lives in the parent.
module rr_arb2
    import regctrl_pkg::*;
(
    input  logic [1:0] req,
    input  wb_src_e    last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == WB_LSU));
        gnt[1] = req[1] & (~req[0] | (last == WB_ALU));
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single write port of reg2r1w between the
// ALU (req0) and the load/store unit (req1), registers the granted write,
// and keeps a per-register busy scoreboard for RAW stall detection.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/addr/data, req0_ready  ALU writeback handshake
//   req1_valid/addr/data, req1_ready  LSU writeback handshake
//   issue_valid, issue_addr         decode issued a register-writing instr
//   wr_en, wr_addr, wr_data         registered write to reg2r1w
//   busy[DEPTH]                     bit i = register i has a write pending
//   gnt_last                        id of the most recent grant
module regfile_wb_arbiter
    import regctrl_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic [DEPTH-1:0] busy,
    output logic             gnt_last
);

    wb_src_e          last_q;
    logic [1:0]       gnt;
    logic             xfer_p0;
    logic [AW-1:0]    addr_p0;
    logic [WIDTH-1:0] data_p0;

    logic             vld_p1;
    logic [AW-1:0]    wr_addr_p1;
    logic [WIDTH-1:0] wr_data_p1;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    // Stage p0: arbitration and data select (combinational)
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer_p0    = gnt[0] | gnt[1];
    assign addr_p0    = gnt[1] ? req1_addr : req0_addr;
    assign data_p0    = gnt[1] ? req1_data : req0_data;

    // Clear on commit first, then set on issue so a new producer wins a
    // same-edge collision on the same register.
    always_comb begin
        busy_nxt = busy_q;
        if (vld_p1) begin
            busy_nxt[wr_addr_p1] = 1'b0;
        end
        if (issue_valid) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    // Stage p1: registered write towards reg2r1w, pointer and scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            last_q     <= WB_LSU;
            busy_q     <= '0;
        end else begin
            vld_p1 <= xfer_p0;
            if (xfer_p0) begin
                wr_addr_p1 <= addr_p0;
                wr_data_p1 <= data_p0;
                last_q     <= gnt[1] ? WB_LSU : WB_ALU;
            end
            busy_q <= busy_nxt;
        end
    end

    assign wr_en    = vld_p1;
    assign wr_addr  = wr_addr_p1;
    assign wr_data  = wr_data_p1;
    assign busy     = busy_q;
    assign gnt_last = last_q;

endmodule
